// File: rtl/cardinal_nic_if.sv
// Processor register port and router inject/eject port of one cardinal_nic.
// The slave modport is the NIC side; the master modport is the processor/router side.
interface cardinal_nic_if #(
    parameter int DATA_W = 64
);
    logic [1:0]        addr;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] d_out;
    logic              nicEn;
    logic              nicWrEn;
    logic              net_so;
    logic              net_ro;
    logic [DATA_W-1:0] net_do;
    logic              net_polarity;
    logic              net_si;
    logic              net_ri;
    logic [DATA_W-1:0] net_di;

    modport slave (
        input  addr, d_in, nicEn, nicWrEn, net_ro, net_polarity, net_si, net_di,
        output d_out, net_so, net_do, net_ri
    );

    modport master (
        output addr, d_in, nicEn, nicWrEn, net_ro, net_polarity, net_si, net_di,
        input  d_out, net_so, net_do, net_ri
    );
endinterface

// File: rtl/cardinal_nic.sv
// Network interface controller: one-packet output buffer (processor to router)
// and one-packet input buffer (router to processor), each with a full flag.
module cardinal_nic #(
    parameter int DATA_W = 64,
    parameter int VC_BIT = 63
) (
    input  logic           clk,
    input  logic           reset,
    cardinal_nic_if.slave  bus
);
    localparam logic [1:0] ADDR_ICB      = 2'b00;
    localparam logic [1:0] ADDR_ICB_STAT = 2'b01;
    localparam logic [1:0] ADDR_OCB      = 2'b10;
    localparam logic [1:0] ADDR_OCB_STAT = 2'b11;

    logic [DATA_W-1:0] ocb;
    logic [DATA_W-1:0] icb;
    logic              ocb_full;
    logic              icb_full;
    logic [DATA_W-1:0] rd_data;
    logic              rd_en;
    logic              ocb_wr;
    logic              icb_cap;
    logic              icb_pop;

    assign rd_en   = bus.nicEn & ~bus.nicWrEn;
    assign ocb_wr  = bus.nicEn & bus.nicWrEn & (bus.addr == ADDR_OCB) & ~ocb_full;
    assign icb_cap = bus.net_si & bus.net_ri;
    assign icb_pop = rd_en & (bus.addr == ADDR_ICB) & icb_full;

    // Inject only when the packet's VC bit matches the router's active channel.
    assign bus.net_so = ocb_full & bus.net_ro & (ocb[VC_BIT] == bus.net_polarity);
    assign bus.net_do = ocb;
    assign bus.net_ri = reset & ~icb_full;

    always_comb begin
        rd_data = '0;
        if (rd_en) begin
            case (bus.addr)
                ADDR_ICB:      rd_data = icb;
                ADDR_ICB_STAT: rd_data = {{(DATA_W-1){1'b0}}, icb_full};
                ADDR_OCB_STAT: rd_data = {{(DATA_W-1){1'b0}}, ocb_full};
                default:       rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ocb       <= '0;
            icb       <= '0;
            ocb_full  <= 1'b0;
            icb_full  <= 1'b0;
            bus.d_out <= '0;
        end else begin
            bus.d_out <= rd_data;
            // ocb_wr already requires an empty buffer, so it never races a transfer.
            if (bus.net_so) begin
                ocb_full <= 1'b0;
            end else if (ocb_wr) begin
                ocb      <= bus.d_in;
                ocb_full <= 1'b1;
            end
            if (icb_cap) begin
                icb      <= bus.net_di;
                icb_full <= 1'b1;
            end else if (icb_pop) begin
                icb_full <= 1'b0;
            end
        end
    end
endmodule

// File: doc/cardinal_nic.md
Name: cardinal_nic

Overview:
- Network interface controller that sits directly upstream/downstream of one cardinal_mesh node.
- It connects a processor-side register interface to that node's router port: pesi/pedi/peri on the inject side, peso/pedo/pero on the eject side, plus polarity.
- It holds one output-channel buffer (processor to network) and one input-channel buffer (network to processor), each with a full flag.
- Network injection is gated by the router's polarity so that a packet's VC bit matches the router's active virtual channel.

Parameters:
- DATA_W, 64, flit/packet width on both the processor and network sides.
- VC_BIT, 63, bit index of the packet virtual-channel bit compared against polarity.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- addr  input  2  processor register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
- d_in  input  DATA_W  processor write data.
- d_out  output  DATA_W  processor read data, registered.
- nicEn  input  1  processor access enable.
- nicWrEn  input  1  1 = write, 0 = read; qualified by nicEn.
- net_so  output  1  valid to router; drives nodeXY_pesi.
- net_ro  input  1  router ready; driven from nodeXY_peri.
- net_do  output  DATA_W  packet to router; drives nodeXY_pedi.
- net_polarity  input  1  router polarity; driven from nodeXY_polarity.
- net_si  input  1  valid from router; driven from nodeXY_peso.
- net_ri  output  1  ready to router; drives nodeXY_pero.
- net_di  input  DATA_W  packet from router; driven from nodeXY_pedo.

Behaviour:
- Reset (reset=0, asynchronous):
  - ocb_full=0, icb_full=0, ocb=0, icb=0, d_out=0.
  - Consequently net_so=0 and net_ri=0 while reset=0.
- Output channel buffer (OCB):
  - Write when nicEn & nicWrEn & addr==10 & !ocb_full: ocb<=d_in and ocb_full<=1 at the edge.
  - A write while ocb_full=1 is dropped silently; ocb is unchanged.
- Inject:
  - net_so = ocb_full & net_ro & (ocb[VC_BIT]==net_polarity). This is combinational from registers and inputs.
  - net_do = ocb at all times.
  - A transfer happens on any edge where net_so=1; ocb_full<=0 at that edge.
  - A processor write in the same cycle as a transfer is dropped, because ocb_full is still 1 in that cycle.
  - Next-write-to-inject latency is 1 cycle minimum: write at edge N, net_so can be 1 in cycle N+1.
  - If the VC bit mismatches polarity, net_so stays 0 and the NIC waits. Polarity toggling makes injection possible within 2 cycles once net_ro=1.
- Input channel buffer (ICB):
  - net_ri = reset & !icb_full.
  - On an edge with net_si & net_ri: icb<=net_di and icb_full<=1.
  - net_si while net_ri=0 is ignored. The router must hold its data; the NIC does not capture it.
- Processor read (nicEn & !nicWrEn), registered; d_out is valid the cycle after the request:
  - addr 00: d_out<=icb. If icb_full=1, icb_full<=0 at the same edge, so net_ri rises the next cycle.
  - addr 01: d_out<={63'b0, icb_full}.
  - addr 11: d_out<={63'b0, ocb_full}.
  - addr 10: d_out<=0.
- Non-read cycles: d_out<=0 when nicEn=0, and on write cycles.
- Simultaneous events:
  - A read of 00 in the same cycle as net_si cannot capture, because net_ri=0 while full.
  - A read of 00 while empty returns stale icb and leaves the flags unchanged.
  - Processor writes to addr 00/01/11 are ignored.
- Reset asserted mid-transfer:
  - All flags clear immediately and any buffered packet is lost.
  - net_so and net_ri drop asynchronously.

Test Plan:
1. Reset then release: d_out=0, net_so=0, net_ri=1 the first cycle after release; read addr 11 returns 0 and addr 01 returns 0.
2. Write 64'h8000_0000_0000_00AA to addr 10 with net_ro=1, net_polarity=0: net_so stays 0. When polarity goes to 1, net_so=1 for exactly one cycle with net_do=8000_0000_0000_00AA; ocb_full clears and a status read of 11 returns 0.
3. OCB full with net_ro=0; write 64'h55 to addr 10: write dropped. After net_ro=1 and polarity match, net_do still shows the first packet, not 55.
4. Router sends net_si=1 with net_di=64'h1234: net_ri drops next cycle and read 01 returns 1. A second net_si=1 with 64'h5678 is not captured. Read 00 gives d_out=1234 the next cycle; net_ri=1 the cycle after the read edge.
5. Back-to-back injects: write, inject, write again on the same edge the first packet transfers. Second write dropped; rewrite next cycle accepted and transferred with matching polarity.
6. Assert reset while ocb_full=1 and icb_full=1: net_so=0, net_ri=0 and d_out=0 immediately. After release, status reads return 0.
